// File: rtl/edf_claim_arbiter.sv
// Serial earliest-deadline scan over the gateway cells, plus the hart claim handshake.
// One source is evaluated per cycle; the winner is committed once per NSource+1 cycles.
module edf_claim_arbiter #(
    parameter int NSource = 8,
    parameter int TsWidth = 64,
    parameter int IdWidth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic [NSource-1:0]         ip_i,
    input  logic [NSource*TsWidth-1:0] dl_i,
    input  logic                       claim_req_i,
    output logic                       claim_ack_o,
    output logic [IdWidth-1:0]         claim_id_o,
    output logic [NSource-1:0]         claim_o,
    output logic                       irq_o,
    output logic [IdWidth-1:0]         best_id_o,
    output logic [TsWidth-1:0]         best_dl_o
);

    // state  | meaning
    // SCAN   | evaluate source idx against the running candidate
    // COMMIT | publish the candidate as the new winner
    // CLAIM  | acknowledge the hart and pulse the winner's claim line
    // FLUSH  | let the claimed cell drop its pending flag
    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        COMMIT = 2'd1,
        CLAIM  = 2'd2,
        FLUSH  = 2'd3
    } state_e;

    localparam int IdxW = (NSource > 1) ? $clog2(NSource) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NSource - 1);

    state_e               state_q, state_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 cand_valid_q, cand_valid_d;
    logic [IdxW-1:0]      cand_idx_q, cand_idx_d;
    logic [TsWidth-1:0]   cand_dl_q, cand_dl_d;
    logic [IdWidth-1:0]   best_id_q, best_id_d;
    logic [TsWidth-1:0]   best_dl_q, best_dl_d;
    logic [IdWidth-1:0]   claim_id_q, claim_id_d;

    logic [TsWidth-1:0]   cur_dl;
    logic [NSource-1:0]   best_hit;
    logic [NSource-1:0]   claim_vec;
    logic [IdWidth-1:0]   claim_id_now;

    assign cur_dl = dl_i[idx_q*TsWidth +: TsWidth];

    // A winner whose pending flag has since dropped is treated as stale and not claimed.
    always_comb begin
        for (int k = 0; k < NSource; k++) begin
            best_hit[k] = (best_id_q == IdWidth'(k + 1));
        end
    end

    assign claim_vec    = best_hit & ip_i;
    assign claim_id_now = (|claim_vec) ? best_id_q : '0;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cand_valid_d = cand_valid_q;
        cand_idx_d   = cand_idx_q;
        cand_dl_d    = cand_dl_q;
        best_id_d    = best_id_q;
        best_dl_d    = best_dl_q;
        claim_id_d   = claim_id_q;

        case (state_q)
            SCAN: begin
                if (claim_req_i) begin
                    state_d = CLAIM;
                end else begin
                    if (ip_i[idx_q] && (!cand_valid_q || (cur_dl < cand_dl_q))) begin
                        cand_valid_d = 1'b1;
                        cand_idx_d   = idx_q;
                        cand_dl_d    = cur_dl;
                    end
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = COMMIT;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            COMMIT: begin
                if (claim_req_i) begin
                    state_d = CLAIM;
                end else begin
                    if (cand_valid_q) begin
                        best_id_d = IdWidth'(cand_idx_q) + IdWidth'(1);
                        best_dl_d = cand_dl_q;
                    end else begin
                        best_id_d = '0;
                        best_dl_d = '0;
                    end
                    cand_valid_d = 1'b0;
                    state_d      = SCAN;
                end
            end
            CLAIM: begin
                claim_id_d   = claim_id_now;
                best_id_d    = '0;
                best_dl_d    = '0;
                idx_d        = '0;
                cand_valid_d = 1'b0;
                state_d      = FLUSH;
            end
            FLUSH: begin
                state_d = SCAN;
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= SCAN;
            idx_q        <= '0;
            cand_valid_q <= 1'b0;
            cand_idx_q   <= '0;
            cand_dl_q    <= '0;
            best_id_q    <= '0;
            best_dl_q    <= '0;
            claim_id_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cand_valid_q <= cand_valid_d;
            cand_idx_q   <= cand_idx_d;
            cand_dl_q    <= cand_dl_d;
            best_id_q    <= best_id_d;
            best_dl_q    <= best_dl_d;
            claim_id_q   <= claim_id_d;
        end
    end

    // Ack, claim pulse and live claim ID decode straight from the CLAIM state so that an
    // asynchronous reset during CLAIM removes them immediately.
    assign claim_ack_o = (state_q == CLAIM);
    assign claim_o     = (state_q == CLAIM) ? claim_vec : '0;
    assign claim_id_o  = (state_q == CLAIM) ? claim_id_now : claim_id_q;
    assign irq_o       = en_i && (best_id_q != '0);
    assign best_id_o   = best_id_q;
    assign best_dl_o   = best_dl_q;

endmodule

// File: doc/edf_claim_arbiter.md
Name: edf_claim_arbiter

Overview:
- Consumer side of the EDF gateway array. Reads the pending flags and absolute deadlines of NSource gateway cells and serially scans them to find the pending source with the earliest deadline.
- Raises the hart interrupt line for that source.
- Serves the hart's claim handshake by returning the winning ID and pulsing the one-hot claim line back to that gateway cell.

Parameters:
- NSource, 8, number of gateway cells; must be at least 2.
- TsWidth, 64, deadline width; must match the gateway cell.
- IdWidth, 4, width of a source ID; must satisfy 2**IdWidth > NSource. ID 0 means "none"; sources are numbered 1..NSource.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- en_i  in  1  global interrupt enable; gates irq_o only
- ip_i  in  NSource  pending flag per cell; bit k is source k+1
- dl_i  in  NSource*TsWidth  flattened deadlines; slice k is source k+1
- claim_req_i  in  1  hart claim request, single-cycle pulse
- claim_ack_o  out  1  one-cycle acknowledge; claim_id_o is valid in this cycle
- claim_id_o  out  IdWidth  claimed source ID; 0 if nothing is claimable
- claim_o  out  NSource  one-hot claim pulse to the gateway cells
- irq_o  out  1  interrupt request to the hart
- best_id_o  out  IdWidth  committed winner ID; 0 if none
- best_dl_o  out  TsWidth  committed winner deadline; 0 if none

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in SCAN, idx=0, candidate invalid.
- FSM states: SCAN, COMMIT, CLAIM, FLUSH.
- SCAN:
  - One source is evaluated per cycle at index idx.
  - Source idx replaces the candidate if ip_i[idx]=1 and either (candidate invalid) or (dl_i[idx] < cand_dl). The compare is unsigned and strict, so on equal deadlines the lower index wins.
  - idx increments each cycle. When idx==NSource-1 is evaluated, idx wraps to 0 and the FSM moves to COMMIT.
- COMMIT (one cycle):
  - If the candidate is valid: best_id_q <= cand_idx+1 and best_dl_q <= cand_dl. Otherwise both are cleared to 0.
  - Candidate is invalidated.
  - Next state is SCAN.
  - A full refresh period is NSource+1 cycles.
- irq_o = en_i && (best_id_q != 0). This is combinational from registered state, so irq_o updates the cycle after COMMIT.
- best_id_o and best_dl_o are driven directly from best_id_q and best_dl_q.
- Claim: claim_req_i is sampled in SCAN or COMMIT; it has priority over a COMMIT update in the same cycle. The FSM moves to CLAIM, abandoning the scan in progress.
- CLAIM (one cycle):
  - claim_ack_o = 1.
  - If best_id_q != 0 and ip_i[best_id_q-1] = 1: claim_id_o = best_id_q and claim_o[best_id_q-1] = 1.
  - Otherwise (stale winner, e.g. its pending flag was cleared by a config write): claim_id_o = 0 and claim_o = 0.
  - best_id_q and best_dl_q are cleared, which drops irq_o the next cycle.
  - idx=0, candidate invalidated. Next state is FLUSH.
- FLUSH (one cycle):
  - Waits for the claimed cell's pending flag to deassert (the cell registers its claim input).
  - claim_req_i is ignored in CLAIM and FLUSH. The hart must not reissue a claim until it has seen claim_ack_o.
  - Next state is SCAN.
- claim_id_o holds its value until the next CLAIM. claim_ack_o and claim_o are single-cycle pulses, and claim_o is never multi-hot.
- en_i=0:
  - The scan continues and best_* continue to update; only irq_o is masked.
  - A claim with en_i=0 still behaves normally.
- ip_i and dl_i may change at any time. Each source's value is sampled when it is scanned; changes are reflected in the next commit.
- Reset mid-operation returns everything to the reset values immediately. A pending claim is lost and no claim_o pulse is emitted.

Test Plan:
- No sources pending for 3 full periods -> irq_o=0, best_id_o=0. A claim -> claim_ack_o=1, claim_id_o=0, claim_o=0.
- NSource=8, src3 pending with dl=100, src6 pending with dl=50 -> after the first commit, best_id_o=6, best_dl_o=50, irq_o=1. Claim -> claim_id_o=6, claim_o=8'b0010_0000 for one cycle. Model drops src6; after the next commit best_id_o=3.
- Tie: src2 and src5 both pending with dl=0x40 -> best_id_o=2.
- Deadline compare near the top of the range: src1 dl=64'hFFFF_FFFF_FFFF_FFFF, src2 dl=64'h0 -> best_id_o=2 (unsigned compare).
- Stale winner: best_id_o=4, then ip_i[3] is dropped, then a claim before the next commit -> claim_id_o=0, claim_o=0, irq_o=0 the next cycle.
- en_i=0 with src1 pending -> best_id_o=1, irq_o=0. Raise en_i -> irq_o=1 the same cycle. Assert rst_ni low during CLAIM -> all outputs 0 and no claim_o pulse.
